// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU/video memory bus arbiter.
package cpu_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_VID = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the CPU and video requesters.
// ARB_VIDEO_PRIORITY_EN: video wins every tie instead of round-robin.
module arb_pick
  import cpu_bus_pkg::*;
(
  input  logic cpuReq,
  input  logic vidReq,
  input  logic lastGrant,
  output logic grantValid,
  output logic grantId
);

  assign grantValid = cpuReq | vidReq;

`ifdef ARB_VIDEO_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = lastGrant;

  always_comb begin
    grantId = vidReq ? REQ_VID : REQ_CPU;
  end
`else
  always_comb begin
    grantId = REQ_CPU;
    if (cpuReq && vidReq) begin
      // Tie goes to whichever side did not win last time.
      grantId = (lastGrant == REQ_CPU) ? REQ_VID : REQ_CPU;
    end else if (vidReq) begin
      grantId = REQ_VID;
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU, video) arbiter driving one registered memory access at a time.
// ARB_VIDEO_PRIORITY_EN (applied inside arb_pick) gives video fixed priority.
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int READ_LATENCY = 1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpuReq,
  input  logic        cpuWrite,
  input  logic [15:0] cpuAddress,
  input  logic [7:0]  cpuDataOut,
  output logic [7:0]  cpuDataIn,
  output logic        cpuAck,
  input  logic        vidReq,
  input  logic        vidWrite,
  input  logic [15:0] vidAddress,
  input  logic [7:0]  vidDataOut,
  output logic [7:0]  vidDataIn,
  output logic        vidAck,
  output logic        memRead,
  output logic        memWrite,
  output logic [15:0] memAddress,
  output logic [7:0]  memDataOut,
  input  logic [7:0]  memDataIn
);

  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

  arb_state_t  state, state_nxt;
  logic        grant_valid, grant_id;
  logic        gnt_id, last_grant, req_write;
  logic        win_write;
  logic [15:0] win_addr;
  logic [7:0]  win_data;
  logic [1:0]  lat_cnt;
  logic        load, cnt_load, capture, ack_nxt, rd_nxt, wr_nxt;

  arb_pick u_pick (
    .cpuReq     (cpuReq),
    .vidReq     (vidReq),
    .lastGrant  (last_grant),
    .grantValid (grant_valid),
    .grantId    (grant_id)
  );

  assign win_write = (grant_id == REQ_VID) ? vidWrite   : cpuWrite;
  assign win_addr  = (grant_id == REQ_VID) ? vidAddress : cpuAddress;
  assign win_data  = (grant_id == REQ_VID) ? vidDataOut : cpuDataOut;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    cnt_load  = 1'b0;
    capture   = 1'b0;
    ack_nxt   = 1'b0;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (grant_valid) begin
          load      = 1'b1;
          rd_nxt    = !win_write;
          wr_nxt    = win_write;
          state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (req_write) begin
          ack_nxt   = 1'b1;
          state_nxt = ARB_DONE;
        end else begin
          cnt_load  = 1'b1;
          state_nxt = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (lat_cnt == 2'd0) begin
          capture   = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = ARB_DONE;
        end
      end
      ARB_DONE: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // Latency counter only matters inside WAIT, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cnt_load)
      lat_cnt <= LAT_INIT;
    else if (state == ARB_WAIT && lat_cnt != 2'd0)
      lat_cnt <= lat_cnt - 2'd1;
  end

  // Strobes are registered from IDLE so they are high exactly during ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memRead    <= 1'b0;
      memWrite   <= 1'b0;
      memAddress <= '0;
      memDataOut <= '0;
      req_write  <= 1'b0;
      gnt_id     <= REQ_CPU;
      last_grant <= REQ_VID;
      cpuAck     <= 1'b0;
      vidAck     <= 1'b0;
      cpuDataIn  <= '0;
      vidDataIn  <= '0;
    end else begin
      memRead  <= rd_nxt;
      memWrite <= wr_nxt;
      if (load) begin
        memAddress <= win_addr;
        req_write  <= win_write;
        gnt_id     <= grant_id;
        if (win_write) memDataOut <= win_data;
      end
      cpuAck <= ack_nxt && (gnt_id == REQ_CPU);
      vidAck <= ack_nxt && (gnt_id == REQ_VID);
      if (capture) begin
        if (gnt_id == REQ_VID) vidDataIn <= memDataIn;
        else                   cpuDataIn <= memDataIn;
      end
      if (state == ARB_DONE) last_grant <= gnt_id;
    end
  end

endmodule
